naviss_top: RTL and testbench

- Counter-based time-to-digital converter (TDC) in a single-clock Tiny-Tapeout-style wrapper with packed 8-bit I/O.
- Measures the number of clock cycles between a rising edge on start and the following rising edge on stop.
- Sends the 16-bit result as two 8N1 UART frames on io_out[0].

---
 rtl/naviss_top.sv | 159 +++++++++++++++
 tb/tb_naviss_top.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/naviss_top.sv
// Counter-based time-to-digital converter: counts clk cycles from a start rise to a stop rise
// and ships the 16-bit result as two back-to-back 8N1 UART frames (high byte first).
module naviss_top #(
  parameter int CLKS_PER_BIT = 8,
  parameter int COUNT_W      = 16
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_BIT - 1);

  // state     | meaning
  // S_IDLE    | waiting for a start edge, uart idle high
  // S_MEASURE | counting cycles until the stop edge
  // S_SEND_HI | shifting out result[15:8]
  // S_SEND_LO | shifting out result[7:0], then back to idle
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_SEND_HI = 2'd2,
    S_SEND_LO = 2'd3
  } state_t;

  logic w_clk;
  logic w_rst_n;
  logic w_start_pin;
  logic w_stop_pin;
  logic w_unused;

  assign w_clk       = io_in[0];
  assign w_rst_n     = io_in[1];
  assign w_start_pin = io_in[2];
  assign w_stop_pin  = io_in[3];
  assign w_unused    = ^io_in[7:4];

  logic r_start_s1, r_start_s2, r_start_prev;
  logic r_stop_s1, r_stop_s2, r_stop_prev;
  logic w_start_pulse;
  logic w_stop_pulse;

  // Identical three-stage paths on start and stop, so their latency cancels out.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_start_s1   <= 1'b0;
      r_start_s2   <= 1'b0;
      r_start_prev <= 1'b0;
      r_stop_s1    <= 1'b0;
      r_stop_s2    <= 1'b0;
      r_stop_prev  <= 1'b0;
    end else begin
      r_start_s1   <= w_start_pin;
      r_start_s2   <= r_start_s1;
      r_start_prev <= r_start_s2;
      r_stop_s1    <= w_stop_pin;
      r_stop_s2    <= r_stop_s1;
      r_stop_prev  <= r_stop_s2;
    end
  end

  assign w_start_pulse = r_start_s2 & ~r_start_prev;
  assign w_stop_pulse  = r_stop_s2 & ~r_stop_prev;

  state_t              r_state;
  logic [COUNT_W-1:0]  r_count;
  logic [COUNT_W-1:0]  r_result;
  logic                r_overflow;
  logic                r_tx;
  logic                r_measuring;
  logic                r_busy;
  logic [8:0]          r_shift;
  logic [TW-1:0]       r_tick;
  logic [3:0]          r_bit;

  logic                w_count_max;
  logic [COUNT_W-1:0]  w_meas_val;

  assign w_count_max = &r_count;
  assign w_meas_val  = w_count_max ? '1 : r_count + COUNT_W'(1);

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_tx        <= 1'b1;
      r_measuring <= 1'b0;
      r_busy      <= 1'b0;
      r_shift     <= '0;
      r_tick      <= '0;
      r_bit       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_pulse) begin
            r_overflow <= 1'b0;
            if (w_stop_pulse) begin
              r_result <= '0;
              r_state  <= S_SEND_HI;
              r_busy   <= 1'b1;
              r_tx     <= 1'b0;
              r_shift  <= {1'b1, 8'h00};
              r_tick   <= TICK_MAX;
              r_bit    <= '0;
            end else begin
              r_count     <= '0;
              r_state     <= S_MEASURE;
              r_measuring <= 1'b1;
            end
          end
        end
        S_MEASURE: begin
          if (w_count_max) r_overflow <= 1'b1;
          else             r_count    <= r_count + COUNT_W'(1);
          if (w_stop_pulse) begin
            r_result    <= w_meas_val;
            r_state     <= S_SEND_HI;
            r_measuring <= 1'b0;
            r_busy      <= 1'b1;
            r_tx        <= 1'b0;
            r_shift     <= {1'b1, w_meas_val[COUNT_W-1 -: 8]};
            r_tick      <= TICK_MAX;
            r_bit       <= '0;
          end
        end
        S_SEND_HI, S_SEND_LO: begin
          if (r_tick != '0) begin
            r_tick <= r_tick - TW'(1);
          end else begin
            r_tick <= TICK_MAX;
            if (r_bit == 4'd9) begin
              // Stop bit done: chain the low byte immediately, or finish.
              if (r_state == S_SEND_HI) begin
                r_state <= S_SEND_LO;
                r_tx    <= 1'b0;
                r_shift <= {1'b1, r_result[7:0]};
                r_bit   <= '0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_tx    <= 1'b1;
              end
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= {1'b1, r_shift[8:1]};
              r_bit   <= r_bit + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_out = {4'b0000, r_overflow, r_busy, r_measuring, r_tx};

endmodule

// File: tb/tb_naviss_top.sv
// Self-checking bench for naviss_top: drives start/stop intervals and decodes the UART output
// against expected values computed from the interval length.
module tb_naviss_top;
  localparam int CPB = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [3:0] junk  = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  int meas_cnt = 0;
  int low_cnt = 0;

  assign io_in = {junk, stop, start, rst_n, clk};

  naviss_top #(.CLKS_PER_BIT(CPB), .COUNT_W(16)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (io_out[2] === 1'b1) busy_cnt++;
    if (io_out[1] === 1'b1) meas_cnt++;
    if (io_out[0] === 1'b0) low_cnt++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_count(int d);
    int v;
    v = (d >= 65535) ? 65535 : d;
    return v[15:0];
  endfunction

  function automatic logic exp_ovf(int d);
    return (d >= 65536);
  endfunction

  task automatic do_measure(int d);
    start = 1'b1;
    if (d > 0) repeat (d) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic rx_pair(output logic [7:0] b0, output logic [7:0] b1,
                         output int gap, output bit ok);
    int n;
    int t0;
    int w;
    logic [7:0] b;
    n = 0; t0 = 0; ok = 1'b1; b0 = '0; b1 = '0; gap = 0; b = '0;
    for (int f = 0; f < 2; f++) begin
      w = 0;
      while (io_out[0] !== 1'b0 && w < 400) begin @(negedge clk); n++; w++; end
      if (io_out[0] !== 1'b0) begin ok = 1'b0; return; end
      if (f == 0) t0 = n; else gap = n - t0;
      repeat (CPB/2) begin @(negedge clk); n++; end
      if (io_out[0] !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) begin @(negedge clk); n++; end
        b[i] = io_out[0];
      end
      repeat (CPB) begin @(negedge clk); n++; end
      if (io_out[0] !== 1'b1) ok = 1'b0;
      if (f == 0) b0 = b; else b1 = b;
    end
    repeat (CPB + 2) @(negedge clk);
  endtask

  task automatic test_reset;
    int bad;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      stop  = 1'($urandom_range(0, 1));
      n_cmp++;
      if (io_out !== 8'h01) begin
        n_bad++;
        $display("FAIL reset_hold: io_out=%h expected 01", io_out);
      end
    end
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if (io_out !== 8'h01) begin
        n_bad++;
        $display("FAIL reset_release: cycle %0d io_out=%h expected 01", i, io_out);
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] b0, b1; int gap; bit ok; int bz, mz;
    bz = busy_cnt; mz = meas_cnt;
    do_measure(100);
    rx_pair(b0, b1, gap, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_framing: ok=%0d expected 1", ok); end
    n_cmp++; if ({b0, b1} !== exp_count(100)) begin n_bad++; $display("FAIL basic_value: got %h%h expected %h", b0, b1, exp_count(100)); end
    n_cmp++; if (gap !== 10*CPB) begin n_bad++; $display("FAIL basic_frame_len: got %0d expected %0d", gap, 10*CPB); end
    n_cmp++; if (busy_cnt - bz !== 20*CPB) begin n_bad++; $display("FAIL basic_busy: got %0d expected %0d", busy_cnt - bz, 20*CPB); end
    n_cmp++; if (meas_cnt - mz !== 100) begin n_bad++; $display("FAIL basic_measuring: got %0d expected 100", meas_cnt - mz); end
    n_cmp++; if (io_out !== 8'h01) begin n_bad++; $display("FAIL basic_idle: io_out=%h expected 01", io_out); end
  endtask

  task automatic test_large;
    logic [7:0] b0, b1; int gap; bit ok;
    do_measure(1000);
    rx_pair(b0, b1, gap, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL large_framing: ok=%0d expected 1", ok); end
    n_cmp++; if ({b0, b1} !== 16'h03E8) begin n_bad++; $display("FAIL large_value: got %h%h expected 03e8", b0, b1); end
    n_cmp++; if (io_out[3] !== 1'b0) begin n_bad++; $display("FAIL large_overflow: got %b expected 0", io_out[3]); end
  endtask

  task automatic test_no_start;
    int lz, bz;
    lz = low_cnt; bz = busy_cnt;
    for (int i = 0; i < 3; i++) begin
      stop = 1'b1; repeat (3) @(negedge clk);
      stop = 1'b0; repeat (10) @(negedge clk);
    end
    repeat (60) @(negedge clk);
    n_cmp++; if (low_cnt - lz !== 0) begin n_bad++; $display("FAIL stop_only_uart: low cycles=%0d expected 0", low_cnt - lz); end
    n_cmp++; if (busy_cnt - bz !== 0) begin n_bad++; $display("FAIL stop_only_busy: busy cycles=%0d expected 0", busy_cnt - bz); end
    n_cmp++; if (io_out !== 8'h01) begin n_bad++; $display("FAIL stop_only_idle: io_out=%h expected 01", io_out); end
  endtask

  task automatic test_same_cycle;
    logic [7:0] b0, b1; int gap; bit ok; int mz;
    mz = meas_cnt;
    do_measure(0);
    rx_pair(b0, b1, gap, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL same_framing: ok=%0d expected 1", ok); end
    n_cmp++; if ({b0, b1} !== 16'h0000) begin n_bad++; $display("FAIL same_value: got %h%h expected 0000", b0, b1); end
    n_cmp++; if (meas_cnt - mz !== 0) begin n_bad++; $display("FAIL same_measuring: got %0d expected 0", meas_cnt - mz); end
  endtask

  task automatic test_double_start;
    logic [7:0] b0, b1; int gap; bit ok; int mz;
    mz = meas_cnt;
    start = 1'b1; repeat (10) @(negedge clk);
    start = 1'b0; repeat (20) @(negedge clk);
    start = 1'b1; repeat (20) @(negedge clk);
    stop = 1'b1; @(negedge clk);
    start = 1'b0; stop = 1'b0;
    rx_pair(b0, b1, gap, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL restart_framing: ok=%0d expected 1", ok); end
    n_cmp++; if ({b0, b1} !== exp_count(50)) begin n_bad++; $display("FAIL restart_value: got %h%h expected %h", b0, b1, exp_count(50)); end
    n_cmp++; if (meas_cnt - mz !== 50) begin n_bad++; $display("FAIL restart_measuring: got %0d expected 50", meas_cnt - mz); end
  endtask

  task automatic test_overflow;
    logic [7:0] b0, b1; int gap; bit ok;
    do_measure(70000);
    rx_pair(b0, b1, gap, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ovf_framing: ok=%0d expected 1", ok); end
    n_cmp++; if ({b0, b1} !== exp_count(70000)) begin n_bad++; $display("FAIL ovf_value: got %h%h expected %h", b0, b1, exp_count(70000)); end
    n_cmp++; if (io_out[3] !== exp_ovf(70000)) begin n_bad++; $display("FAIL ovf_flag: got %b expected %b", io_out[3], exp_ovf(70000)); end
  endtask

  task automatic test_random;
    logic [7:0] b0, b1; int gap; bit ok; int d;
    for (int k = 0; k < 4; k++) begin
      d = $urandom_range(1, 1000);
      junk = 4'($urandom);
      do_measure(d);
      rx_pair(b0, b1, gap, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rand_framing: d=%0d ok=%0d expected 1", d, ok); end
      n_cmp++; if ({b0, b1} !== exp_count(d)) begin n_bad++; $display("FAIL rand_value: d=%0d got %h%h expected %h", d, b0, b1, exp_count(d)); end
      n_cmp++; if (io_out !== {4'b0, exp_ovf(d), 3'b001}) begin n_bad++; $display("FAIL rand_idle: d=%0d io_out=%h expected %h", d, io_out, {4'b0, exp_ovf(d), 3'b001}); end
      n_cmp++; if (gap !== 10*CPB) begin n_bad++; $display("FAIL rand_frame_len: got %0d expected %0d", gap, 10*CPB); end
    end
    junk = 4'h0;
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] b0, b1; int gap; bit ok; int w; int lz;
    do_measure(300);
    w = 0;
    while (io_out[0] !== 1'b0 && w < 400) begin @(negedge clk); w++; end
    n_cmp++; if (io_out[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_frame_start: uart=%b expected 0", io_out[0]); end
    repeat (4*CPB + 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (io_out[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_uart: got %b expected 1", io_out[0]); end
    n_cmp++; if (io_out[2] !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", io_out[2]); end
    rst_n = 1'b1;
    lz = low_cnt;
    repeat (30) @(negedge clk);
    n_cmp++; if (low_cnt - lz !== 0) begin n_bad++; $display("FAIL midrst_quiet: low cycles=%0d expected 0", low_cnt - lz); end
    do_measure(10);
    rx_pair(b0, b1, gap, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL midrst_framing: ok=%0d expected 1", ok); end
    n_cmp++; if ({b0, b1} !== 16'h000A) begin n_bad++; $display("FAIL midrst_value: got %h%h expected 000a", b0, b1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_large();
    test_no_start();
    test_same_cycle();
    test_double_start();
    test_overflow();
    test_random();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
